// File: rtl/crc16_check.sv
// crc16_check
// Checks the CRC16 of a received data packet. The packet arrives one
// decoded bit at a time, LSB-first, with the CRC field last. The payload
// is forwarded after a 16-bit delay, so the trailing CRC field is never
// emitted.
//
// Ports
//   clock        : sole clock, rising edge
//   reset        : synchronous, active-high
//   pkt_start    : pulse, data field starts on the following bits
//   in_valid     : in_bit carries an accepted bit this cycle
//   in_bit       : received data/CRC bit
//   pkt_end      : pulse, end of packet
//   out_valid    : out_bit carries a payload bit
//   out_bit      : payload bit, delayed by 16 accepted bits
//   busy         : packet in progress (RUN or CHECK)
//   done         : one-cycle pulse, results below are valid
//   crc_ok       : residual matched and length legal
//   len_err      : fewer than 16 bits, or not a whole number of bytes
//   payload_bits : accepted bits minus 16, floored at 0
module crc16_check (
  input  logic        clock,
  input  logic        reset,
  input  logic        pkt_start,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        pkt_end,
  output logic        out_valid,
  output logic        out_bit,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        len_err,
  output logic [13:0] payload_bits
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  localparam logic [15:0] LFSR_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'h8005;
  // Register contents after a good packet, including the complemented CRC.
  localparam logic [15:0] CRC_RESIDUAL = 16'h800D;
  localparam logic [13:0] CNT_MAX      = 14'h3FFF;
  localparam logic [13:0] CRC_BITS     = 14'd16;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [13:0] cnt_q, cnt_d;
  logic [15:0] dly_q, dly_d;
  logic        out_valid_q, out_valid_d;
  logic        out_bit_q, out_bit_d;
  logic        done_q, done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        len_err_q, len_err_d;
  logic [13:0] payload_bits_q, payload_bits_d;
  logic        restart;
  logic        len_bad;

  function automatic logic [15:0] crc_step(input logic [15:0] lfsr, input logic b);
    logic fb;
    fb = b ^ lfsr[15];
    return {lfsr[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  function automatic logic [13:0] sat_inc(input logic [13:0] c);
    return (c == CNT_MAX) ? c : c + 14'd1;
  endfunction

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    cnt_d          = cnt_q;
    dly_d          = dly_q;
    out_valid_d    = 1'b0;
    out_bit_d      = 1'b0;
    done_d         = 1'b0;
    crc_ok_d       = crc_ok_q;
    len_err_d      = len_err_q;
    payload_bits_d = payload_bits_q;
    restart        = 1'b0;
    len_bad        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pkt_start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        // A new start aborts the current packet silently.
        if (pkt_start) begin
          restart = 1'b1;
        end else begin
          if (in_valid) begin
            lfsr_d = crc_step(lfsr_q, in_bit);
            cnt_d  = sat_inc(cnt_q);
            dly_d  = {dly_q[14:0], in_bit};
            // Only once 16 bits are buffered is the evicted bit known
            // not to belong to the CRC field.
            if (cnt_q >= CRC_BITS) begin
              out_valid_d = 1'b1;
              out_bit_d   = dly_q[15];
            end
          end
          // Results use the post-update values so a bit arriving with
          // pkt_end is included.
          if (pkt_end) begin
            state_d        = CHECK;
            done_d         = 1'b1;
            len_bad        = (cnt_d < CRC_BITS) || (cnt_d[2:0] != 3'd0);
            len_err_d      = len_bad;
            crc_ok_d       = (lfsr_d == CRC_RESIDUAL) && !len_bad;
            payload_bits_d = (cnt_d >= CRC_BITS) ? (cnt_d - CRC_BITS) : 14'd0;
          end
        end
      end
      CHECK: begin
        // done is already showing this cycle; a start here goes
        // straight into the next packet.
        if (pkt_start) begin
          state_d = RUN;
          restart = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      lfsr_d         = LFSR_INIT;
      cnt_d          = 14'd0;
      dly_d          = 16'h0000;
      crc_ok_d       = 1'b0;
      len_err_d      = 1'b0;
      payload_bits_d = 14'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      lfsr_q         <= LFSR_INIT;
      cnt_q          <= 14'd0;
      dly_q          <= 16'h0000;
      out_valid_q    <= 1'b0;
      out_bit_q      <= 1'b0;
      done_q         <= 1'b0;
      crc_ok_q       <= 1'b0;
      len_err_q      <= 1'b0;
      payload_bits_q <= 14'd0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      cnt_q          <= cnt_d;
      dly_q          <= dly_d;
      out_valid_q    <= out_valid_d;
      out_bit_q      <= out_bit_d;
      done_q         <= done_d;
      crc_ok_q       <= crc_ok_d;
      len_err_q      <= len_err_d;
      payload_bits_q <= payload_bits_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_bit      = out_bit_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign crc_ok       = crc_ok_q;
  assign len_err      = len_err_q;
  assign payload_bits = payload_bits_q;

endmodule

// File: tb/tb_crc16_check.sv
// tb_crc16_check
// Directed bench for crc16_check: reset state, good and corrupted packets,
// illegal lengths, abort, reset mid-packet, and back-to-back packets.
module tb_crc16_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_start, in_valid, in_bit, pkt_end;
  logic        out_valid, out_bit, busy, done, crc_ok, len_err;
  logic [13:0] payload_bits;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic tx_q[$];
  logic exp_q[$];
  logic got_q[$];

  crc16_check dut (
    .clock        (clk),
    .reset        (reset),
    .pkt_start    (pkt_start),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .pkt_end      (pkt_end),
    .out_valid    (out_valid),
    .out_bit      (out_bit),
    .busy         (busy),
    .done         (done),
    .crc_ok       (crc_ok),
    .len_err      (len_err),
    .payload_bits (payload_bits)
  );

  always #5 clk = ~clk;

  // Apply inputs, let one rising edge pass, then observe 1 ns later.
  task automatic tick(input logic s, input logic v, input logic b, input logic e);
    pkt_start = s; in_valid = v; in_bit = b; pkt_end = e;
    @(posedge clk);
    #1;
    if (out_valid) got_q.push_back(out_bit);
    if (done) done_cnt++;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_q.push_back(v[i]);
  endtask

  // Reference CRC: init 0xFFFF, poly 0x8005, bits in transmit order.
  function automatic logic [15:0] model_crc();
    logic [15:0] r;
    logic fb;
    r = 16'hFFFF;
    foreach (tx_q[i]) begin
      fb = tx_q[i] ^ r[15];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  // Append complemented CRC; register bit 15 is sent first.
  task automatic push_crc();
    logic [15:0] r;
    r = model_crc();
    for (int i = 15; i >= 0; i--) tx_q.push_back(~r[i]);
  endtask

  task automatic build_data_pkt();
    tx_q.delete();
    push_byte(8'h00); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    exp_q = tx_q;
    push_crc();
  endtask

  // Send tx_q; optionally with random idle gaps, and with pkt_end either
  // on the last bit or on a separate cycle. Returns in the CHECK cycle.
  task automatic send_pkt(input bit gapped, input bit end_on_last);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gapped) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      tick(1'b0, 1'b1, tx_q[i], end_on_last && (i == tx_q.size() - 1));
    end
    if (!end_on_last) tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", out_valid); n_err++; end
    n_vec++; if (out_bit !== 1'b0) begin $display("FAIL reset_out_bit got %b want 0", out_bit); n_err++; end
    n_vec++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_err++; end
    n_vec++; if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); n_err++; end
    n_vec++; if ({crc_ok, len_err} !== 2'b00) begin $display("FAIL reset_flags got %b want 00", {crc_ok, len_err}); n_err++; end
    n_vec++; if (payload_bits !== 14'd0) begin $display("FAIL reset_payload got %0d want 0", payload_bits); n_err++; end
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b0) begin $display("FAIL reset_idle_busy got %b want 0", busy); n_err++; end
  endtask

  task automatic test_zero_len();
    got_q.delete();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b1) begin $display("FAIL zl_busy got %b want 1", busy); n_err++; end
    tx_q.delete();
    for (int i = 0; i < 16; i++) tx_q.push_back(1'b0);
    send_pkt(1'b0, 1'b0);
    n_vec++; if (done !== 1'b1) begin $display("FAIL zl_done got %b want 1", done); n_err++; end
    n_vec++; if (crc_ok !== 1'b1) begin $display("FAIL zl_crc_ok got %b want 1", crc_ok); n_err++; end
    n_vec++; if (len_err !== 1'b0) begin $display("FAIL zl_len_err got %b want 0", len_err); n_err++; end
    n_vec++; if (payload_bits !== 14'd0) begin $display("FAIL zl_payload got %0d want 0", payload_bits); n_err++; end
    n_vec++; if (got_q.size() != 0) begin $display("FAIL zl_out_valid got %0d bits want 0", got_q.size()); n_err++; end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    n_vec++; if ({busy, done} !== 2'b00) begin $display("FAIL zl_after got busy,done=%b want 00", {busy, done}); n_err++; end
    n_vec++; if (crc_ok !== 1'b1) begin $display("FAIL zl_hold got %b want 1", crc_ok); n_err++; end
  endtask

  task automatic test_data_ok();
    int d0;
    got_q.delete();
    d0 = done_cnt;
    build_data_pkt();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(1'b1, 1'b0);
    n_vec++; if (crc_ok !== 1'b1) begin $display("FAIL data_crc_ok got %b want 1", crc_ok); n_err++; end
    n_vec++; if (len_err !== 1'b0) begin $display("FAIL data_len_err got %b want 0", len_err); n_err++; end
    n_vec++; if (payload_bits !== 14'd32) begin $display("FAIL data_payload got %0d want 32", payload_bits); n_err++; end
    n_vec++; if (got_q.size() != 32) begin $display("FAIL data_stream_len got %0d want 32", got_q.size()); n_err++; end
    for (int i = 0; i < 32 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin $display("FAIL data_bit%0d got %b want %b", i, got_q[i], exp_q[i]); n_err++; end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (done_cnt - d0 != 1) begin $display("FAIL data_done_count got %0d want 1", done_cnt - d0); n_err++; end
  endtask

  task automatic test_crc_flip();
    build_data_pkt();
    tx_q[37] = ~tx_q[37];
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (crc_ok !== 1'b0) begin $display("FAIL flip_clear got crc_ok %b want 0", crc_ok); n_err++; end
    send_pkt(1'b1, 1'b0);
    n_vec++; if (crc_ok !== 1'b0) begin $display("FAIL flip_crc_ok got %b want 0", crc_ok); n_err++; end
    n_vec++; if (len_err !== 1'b0) begin $display("FAIL flip_len_err got %b want 0", len_err); n_err++; end
    n_vec++; if (payload_bits !== 14'd32) begin $display("FAIL flip_payload got %0d want 32", payload_bits); n_err++; end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_length();
    tx_q.delete();
    for (int i = 0; i < 12; i++) tx_q.push_back(1'($urandom_range(0, 1)));
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(1'b0, 1'b0);
    n_vec++; if (done !== 1'b1) begin $display("FAIL len12_done got %b want 1", done); n_err++; end
    n_vec++; if ({crc_ok, len_err} !== 2'b01) begin $display("FAIL len12_flags got crc_ok,len_err=%b want 01", {crc_ok, len_err}); n_err++; end
    n_vec++; if (payload_bits !== 14'd0) begin $display("FAIL len12_payload got %0d want 0", payload_bits); n_err++; end
    tx_q.delete();
    for (int i = 0; i < 19; i++) tx_q.push_back(1'($urandom_range(0, 1)));
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(1'b0, 1'b0);
    n_vec++; if ({crc_ok, len_err} !== 2'b01) begin $display("FAIL len19_flags got crc_ok,len_err=%b want 01", {crc_ok, len_err}); n_err++; end
    n_vec++; if (payload_bits !== 14'd3) begin $display("FAIL len19_payload got %0d want 3", payload_bits); n_err++; end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort_and_reset();
    int d0;
    d0 = done_cnt;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++; if ({busy, out_valid, done} !== 3'b100) begin $display("FAIL abort_state got busy,out_valid,done=%b want 100", {busy, out_valid, done}); n_err++; end
    got_q.delete();
    tx_q.delete();
    for (int i = 0; i < 16; i++) tx_q.push_back(1'b0);
    send_pkt(1'b0, 1'b0);
    n_vec++; if (crc_ok !== 1'b1) begin $display("FAIL abort_crc_ok got %b want 1", crc_ok); n_err++; end
    n_vec++; if (payload_bits !== 14'd0) begin $display("FAIL abort_payload got %0d want 0", payload_bits); n_err++; end
    n_vec++; if (done_cnt - d0 != 1) begin $display("FAIL abort_done_count got %0d want 1", done_cnt - d0); n_err++; end
    n_vec++; if (got_q.size() != 0) begin $display("FAIL abort_out_valid got %0d bits want 0", got_q.size()); n_err++; end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    n_vec++; if ({out_valid, out_bit, busy, done, crc_ok, len_err} !== 6'b0) begin
      $display("FAIL midreset_outputs got %b want 000000", {out_valid, out_bit, busy, done, crc_ok, len_err}); n_err++; end
    n_vec++; if (payload_bits !== 14'd0) begin $display("FAIL midreset_payload got %0d want 0", payload_bits); n_err++; end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (done_cnt - d0 != 0) begin $display("FAIL midreset_done_count got %0d want 0", done_cnt - d0); n_err++; end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tx_q.delete();
    for (int i = 0; i < 16; i++) tx_q.push_back(1'b0);
    send_pkt(1'b0, 1'b1);
    n_vec++; if ({done, busy} !== 2'b11) begin $display("FAIL b2b_done_busy got %b want 11", {done, busy}); n_err++; end
    n_vec++; if ({crc_ok, len_err} !== 2'b10) begin $display("FAIL b2b_last_bit got crc_ok,len_err=%b want 10", {crc_ok, len_err}); n_err++; end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if ({busy, done, crc_ok} !== 3'b100) begin $display("FAIL b2b_restart got busy,done,crc_ok=%b want 100", {busy, done, crc_ok}); n_err++; end
    build_data_pkt();
    send_pkt(1'b0, 1'b1);
    n_vec++; if ({done, crc_ok, len_err} !== 3'b110) begin $display("FAIL b2b_second got done,crc_ok,len_err=%b want 110", {done, crc_ok, len_err}); n_err++; end
    n_vec++; if (payload_bits !== 14'd32) begin $display("FAIL b2b_payload got %0d want 32", payload_bits); n_err++; end
    n_vec++; if (got_q.size() != 32) begin $display("FAIL b2b_stream_len got %0d want 32", got_q.size()); n_err++; end
    for (int i = 0; i < 32 && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin $display("FAIL b2b_bit%0d got %b want %b", i, got_q[i], exp_q[i]); n_err++; end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (busy !== 1'b0) begin $display("FAIL b2b_idle got busy %b want 0", busy); n_err++; end
  endtask

  initial begin
    reset = 1'b1; pkt_start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; pkt_end = 1'b0;
    test_reset();
    test_zero_len();
    test_data_ok();
    test_crc_flip();
    test_length();
    test_abort_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
